// File: rtl/sync_frame_pkg.sv
// Shared definitions for the sync-frame transmit path and its detector.
// Holds the FSM state type, the sync word and a small sizing helper.
package sync_frame_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        PAYLOAD,
        GAP
    } state_t;

    // Sync word and length; the detector side imports the same values.
    localparam logic [7:0] SYNC_PATTERN = 8'b00110111;
    localparam int         SYNC_LEN     = 8;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/sync_frame_tx_piso.sv
// Parallel-load, MSB-first shift register for the payload path.
// Ports: clk, reset, load (capture din), shift (left by one), din, msb.
module piso_shift
#(
    parameter int W = 8
)(
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] din,
    output logic         msb
);

    logic [W-1:0] sr;

    always_ff @(posedge clk) begin
        if (reset) begin
            sr <= '0;
        end else if (load) begin
            sr <= din;
        end else if (shift) begin
            sr <= sr << 1;
        end
    end

    assign msb = sr[W-1];

endmodule

// File: rtl/sync_frame_tx.sv
// Serial frame transmitter: sync word, payload word, idle-high gap.
// Ports: clk, reset, start/din/ready handshake, data line, busy, sync_end, done.
module sync_frame_tx
    import sync_frame_pkg::*;
#(
    parameter int                 PAT_LEN = SYNC_LEN,
    parameter logic [PAT_LEN-1:0] PATTERN = PAT_LEN'(SYNC_PATTERN),
    parameter int                 DATA_W  = 8,
    parameter int                 GAP_LEN = 2
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] din,
    output logic              ready,
    output logic              data,
    output logic              busy,
    output logic              sync_end,
    output logic              done
);

    localparam int CW = $clog2(max3(PAT_LEN, DATA_W, GAP_LEN)) + 1;

    localparam logic [CW-1:0] PAT_TOP = CW'(PAT_LEN - 1);
    localparam logic [CW-1:0] DAT_TOP = CW'(DATA_W - 1);
    localparam logic [CW-1:0] GAP_TOP = CW'(GAP_LEN - 1);
    localparam logic [CW-1:0] ONE     = CW'(1);

    state_t             state, state_n;
    logic [CW-1:0]      cnt, cnt_n;
    logic               data_n, busy_n;
    logic               sync_end_n, done_n;
    logic               load, shift;
    logic               msb;
    logic               accept;
    logic               last_gap;
    logic [PAT_LEN-1:0] pat_sh;

    assign last_gap = (state == GAP) && (cnt == '0);
    assign ready    = ~reset && ((state == IDLE) || last_gap);
    assign accept   = start && ready;

    piso_shift #(
        .W (DATA_W)
    ) u_piso (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .shift (shift),
        .din   (din),
        .msb   (msb)
    );

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        load    = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_n = SYNC;
                    cnt_n   = PAT_TOP;
                    load    = 1'b1;
                end
            end
            SYNC: begin
                if (cnt == '0) begin
                    state_n = PAYLOAD;
                    cnt_n   = DAT_TOP;
                end else begin
                    cnt_n = cnt - ONE;
                end
            end
            PAYLOAD: begin
                if (cnt == '0) begin
                    state_n = GAP;
                    cnt_n   = GAP_TOP;
                end else begin
                    cnt_n = cnt - ONE;
                end
            end
            GAP: begin
                if (cnt != '0) begin
                    cnt_n = cnt - ONE;
                end else if (accept) begin
                    // back-to-back frame, no idle bit in between
                    state_n = SYNC;
                    cnt_n   = PAT_TOP;
                    load    = 1'b1;
                end else begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase

        // Outputs are registered, so they are derived from the state
        // being entered. The shift register advances as each payload
        // bit is moved onto the line.
        shift  = (state_n == PAYLOAD);
        pat_sh = PATTERN >> cnt_n;

        data_n = 1'b1;
        if (state_n == SYNC) begin
            data_n = pat_sh[0];
        end else if (state_n == PAYLOAD) begin
            data_n = msb;
        end

        busy_n     = (state_n != IDLE);
        sync_end_n = (state_n == SYNC) && (cnt_n == '0);
        done_n     = (state_n == GAP) && (cnt_n == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            data     <= 1'b1;
            busy     <= 1'b0;
            sync_end <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            data     <= data_n;
            busy     <= busy_n;
            sync_end <= sync_end_n;
            done     <= done_n;
        end
    end

endmodule

// File: tb/tb_sync_frame_tx.sv
// Self-checking bench for sync_frame_tx: queue-based frame model,
// directed scenarios, a line-watching detector model and random traffic.
module tb_sync_frame_tx;

    localparam logic [7:0] PAT = 8'b00110111;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] din;
    logic       ready;
    logic       data;
    logic       busy;
    logic       sync_end;
    logic       done;

    sync_frame_tx dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .din      (din),
        .ready    (ready),
        .data     (data),
        .busy     (busy),
        .sync_end (sync_end),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // expected {busy, data, sync_end, done} for cycles after the current one
    logic [3:0] exp_q[$];
    logic       dlog [0:4095];
    logic       rlog [0:4095];
    int         flags[$];
    int         ses[$];
    int         dones[$];
    logic [7:0] hist = 8'hFF;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic push_frame(input logic [7:0] d);
        for (int i = 7; i >= 0; i--)
            exp_q.push_back({1'b1, PAT[i], (i == 0), 1'b0});
        for (int i = 7; i >= 0; i--)
            exp_q.push_back({1'b1, d[i], 1'b0, 1'b0});
        exp_q.push_back(4'b1100);
        exp_q.push_back(4'b1101);
    endtask

    task automatic step(input logic st, input logic [7:0] d,
                        input logic rst);
        logic       mr;
        logic [3:0] cur;
        @(negedge clk);
        start = st;
        din   = d;
        reset = rst;
        #1;
        mr = !rst && (exp_q.size() == 0);
        check("ready", ready, mr);
        rlog[cyc] = ready;
        @(posedge clk);
        if (rst) exp_q.delete();
        else if (st && mr) push_frame(d);
        cur = (exp_q.size() != 0) ? exp_q.pop_front() : 4'b0100;
        cyc++;
        #1;
        check("busy", busy, cur[3]);
        check("data", data, cur[2]);
        check("sync_end", sync_end, cur[1]);
        check("done", done, cur[0]);
        dlog[cyc] = data;
        if (hist == PAT) flags.push_back(cyc);
        hist = {hist[6:0], data};
        if (sync_end) ses.push_back(cyc);
        if (done) dones.push_back(cyc);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
    endtask

    task automatic clear_logs();
        flags.delete();
        ses.delete();
        dones.delete();
    endtask

    function automatic logic [31:0] bits(input int from, input int n);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < n; i++) v = {v[30:0], dlog[from + i]};
        return v;
    endfunction

    function automatic int qat(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    function automatic int first_ready(input int t);
        for (int c = t + 1; c <= t + 40; c++)
            if (rlog[c] === 1'b1) return c;
        return -1;
    endfunction

    int t;

    initial begin
        reset = 1'b1;
        start = 1'b0;
        din   = 8'h00;

        // reset held, then idle
        for (int i = 0; i < 3; i++) step(1'b1, 8'hAA, 1'b1);
        check("rst_data", data, 1'b1);
        check("rst_busy", busy, 1'b0);
        clear_logs();
        idle(10);
        check("idle_ready", ready, 1'b1);
        check("idle_done_n", dones.size(), 0);

        // single frame A5
        clear_logs();
        t = cyc;
        step(1'b1, 8'hA5, 1'b0);
        idle(20);
        check("a5_bits", bits(t + 1, 18), 18'b001101111010010111);
        check("a5_se_n", ses.size(), 1);
        check("a5_se", qat(ses, 0), t + 8);
        check("a5_done_n", dones.size(), 1);
        check("a5_done", qat(dones, 0), t + 18);
        check("a5_det_n", flags.size(), 1);
        check("a5_det", qat(flags, 0), t + 9);

        // back-to-back frames, start held high
        clear_logs();
        t = cyc;
        step(1'b1, 8'h3C, 1'b0);
        for (int i = 1; i <= 18; i++) step(1'b1, 8'hFF, 1'b0);
        idle(20);
        check("b2b_rdy", first_ready(t), t + 18);
        check("b2b_f1", bits(t + 1, 18), {8'h37, 8'h3C, 2'b11});
        check("b2b_f2", bits(t + 19, 18), {8'h37, 8'hFF, 2'b11});
        check("b2b_done_n", dones.size(), 2);

        // payload equal to the sync word
        clear_logs();
        t = cyc;
        step(1'b1, 8'h37, 1'b0);
        idle(20);
        check("p37_det_n", flags.size(), 2);
        check("p37_det0", qat(flags, 0), t + 9);
        check("p37_det1", qat(flags, 1), t + 17);

        // reset mid-sync
        clear_logs();
        t = cyc;
        step(1'b1, 8'h55, 1'b0);
        idle(4);
        step(1'b0, 8'h00, 1'b1);
        check("mrst_data", data, 1'b1);
        check("mrst_busy", busy, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        check("mrst_rdy", rlog[t + 6], 1'b0);
        idle(20);
        check("mrst_rdy_rel", rlog[t + 7], 1'b1);
        check("mrst_done_n", dones.size(), 0);

        // din changes after acceptance
        clear_logs();
        t = cyc;
        step(1'b1, 8'hC9, 1'b0);
        step(1'b0, 8'h36, 1'b0);
        idle(20);
        check("din_hold", bits(t + 9, 8), 8'hC9);

        // random traffic
        for (int i = 0; i < 500; i++) begin
            step(($urandom_range(0, 2) == 0),
                 8'($urandom),
                 ($urandom_range(0, 99) == 0));
        end
        idle(20);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
